// File: rtl/abs_diff_mon_pkg.sv
// Shared types and default sizing for the absolute-difference error monitor.
package abs_diff_mon_pkg;

    // Sweep sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mon_state_t;

    // Default operand/response widths and error threshold.
    localparam int unsigned DEF_IN_W  = 32'd4;
    localparam int unsigned DEF_OUT_W = 32'd2;
    localparam int unsigned DEF_ET    = 32'd3;

endpackage

// File: rtl/abs_diff_exact.sv
// Exact combinational |a - b| for two unsigned W-bit operands.
// Serves as the golden reference and as the error-magnitude unit.
module abs_diff_exact
    import abs_diff_mon_pkg::*;
#(
    parameter int unsigned W = DEF_OUT_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff
);

    // Subtract the smaller operand from the larger so the result never wraps.
    always_comb begin
        if (a >= b) begin
            diff = a - b;
        end else begin
            diff = b - a;
        end
    end

endmodule

// File: rtl/abs_diff_err_monitor.sv
// Exhaustive error monitor for an approximate |a-b| circuit.
// Sweeps every input vector, compares the returned value against the exact
// result and accumulates mismatch, violation, sum and maximum statistics.
module abs_diff_err_monitor
    import abs_diff_mon_pkg::*;
#(
    parameter int unsigned IN_W  = DEF_IN_W,
    parameter int unsigned OUT_W = DEF_OUT_W,
    parameter int unsigned ET    = DEF_ET
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic [IN_W-1:0]       dut_in,
    input  logic [OUT_W-1:0]      dut_out,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [OUT_W-1:0]      max_err,
    output logic [IN_W:0]         mis_cnt,
    output logic [IN_W:0]         viol_cnt,
    output logic [OUT_W+IN_W-1:0] err_sum
);

    localparam int unsigned HALF_W = IN_W / 32'd2;

    // Operand split and response width must line up with the exact model.
    generate
        if ((IN_W < 32'd2) || ((IN_W % 32'd2) != 32'd0) || (OUT_W != HALF_W)) begin : g_bad_params
            $error("abs_diff_err_monitor: IN_W must be even and >= 2, OUT_W must equal IN_W/2");
        end
    endgenerate

    localparam logic [IN_W-1:0] VEC_ZERO = {IN_W{1'b0}};
    localparam logic [IN_W-1:0] VEC_ONE  = {{(IN_W-1){1'b0}}, 1'b1};
    localparam logic [IN_W-1:0] VEC_LAST = {IN_W{1'b1}};

    mon_state_t             state_r;
    logic [IN_W-1:0]        dut_in_r;
    logic                   primed_r;
    logic                   valid_r;
    logic [OUT_W-1:0]       err_r;
    logic [OUT_W-1:0]       max_err_r;
    logic [IN_W:0]          mis_cnt_r;
    logic [IN_W:0]          viol_cnt_r;
    logic [OUT_W+IN_W-1:0]  err_sum_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   pass_r;

    logic [HALF_W-1:0]      op_a_s;
    logic [HALF_W-1:0]      op_b_s;
    logic [HALF_W-1:0]      exact_s;
    logic [OUT_W-1:0]       err_s;
    logic                   nonzero_s;
    logic                   over_s;
    logic [OUT_W-1:0]       max_nxt_s;
    logic [IN_W:0]          mis_nxt_s;
    logic [IN_W:0]          viol_nxt_s;
    logic [OUT_W+IN_W-1:0]  sum_nxt_s;

    assign op_a_s = dut_in_r[HALF_W-1:0];
    assign op_b_s = dut_in_r[IN_W-1:HALF_W];

    // Golden result for the vector currently driven to the circuit under test.
    abs_diff_exact #(.W(HALF_W)) u_exact (
        .a    (op_a_s),
        .b    (op_b_s),
        .diff (exact_s)
    );

    // Error magnitude between the golden result and the returned value.
    abs_diff_exact #(.W(OUT_W)) u_err (
        .a    (exact_s),
        .b    (dut_out),
        .diff (err_s)
    );

    // Stage-2 update: fold the captured error into the running statistics.
    always_comb begin
        nonzero_s  = (err_r != {OUT_W{1'b0}});
        over_s     = (32'(err_r) > ET);
        max_nxt_s  = max_err_r;
        mis_nxt_s  = mis_cnt_r;
        viol_nxt_s = viol_cnt_r;
        sum_nxt_s  = err_sum_r;
        if (valid_r) begin
            mis_nxt_s  = mis_cnt_r + (IN_W+1)'(nonzero_s);
            viol_nxt_s = viol_cnt_r + (IN_W+1)'(over_s);
            sum_nxt_s  = err_sum_r + (OUT_W+IN_W)'(err_r);
            if (err_r > max_err_r) begin
                max_nxt_s = err_r;
            end else begin
                max_nxt_s = max_err_r;
            end
        end else begin
            max_nxt_s  = max_err_r;
            mis_nxt_s  = mis_cnt_r;
            viol_nxt_s = viol_cnt_r;
            sum_nxt_s  = err_sum_r;
        end
    end

    // Sweep sequencer, vector counter, stage-1 capture and stage-2 accumulators.
    // The first RUN cycle is a bubble so vector 0 is captured one edge after
    // it has been applied for a full cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            dut_in_r   <= VEC_ZERO;
            primed_r   <= 1'b0;
            valid_r    <= 1'b0;
            err_r      <= {OUT_W{1'b0}};
            max_err_r  <= {OUT_W{1'b0}};
            mis_cnt_r  <= {(IN_W+1){1'b0}};
            viol_cnt_r <= {(IN_W+1){1'b0}};
            err_sum_r  <= {(OUT_W+IN_W){1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
        end else begin
            max_err_r  <= max_nxt_s;
            mis_cnt_r  <= mis_nxt_s;
            viol_cnt_r <= viol_nxt_s;
            err_sum_r  <= sum_nxt_s;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    valid_r <= 1'b0;
                    if (start) begin
                        state_r    <= ST_RUN;
                        dut_in_r   <= VEC_ZERO;
                        primed_r   <= 1'b0;
                        max_err_r  <= {OUT_W{1'b0}};
                        mis_cnt_r  <= {(IN_W+1){1'b0}};
                        viol_cnt_r <= {(IN_W+1){1'b0}};
                        err_sum_r  <= {(OUT_W+IN_W){1'b0}};
                        busy_r     <= 1'b1;
                        done_r     <= 1'b0;
                        pass_r     <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state_r <= ST_IDLE;
                        valid_r <= 1'b0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                        pass_r  <= 1'b0;
                    end else if (!primed_r) begin
                        primed_r <= 1'b1;
                        valid_r  <= 1'b0;
                    end else begin
                        err_r   <= err_s;
                        valid_r <= 1'b1;
                        if (dut_in_r == VEC_LAST) begin
                            state_r <= ST_DRAIN;
                        end else begin
                            dut_in_r <= dut_in_r + VEC_ONE;
                        end
                    end
                end
                ST_DRAIN: begin
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                    if (abort) begin
                        state_r <= ST_IDLE;
                        done_r  <= 1'b0;
                        pass_r  <= 1'b0;
                    end else begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                        pass_r  <= (viol_nxt_s == {(IN_W+1){1'b0}});
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    pass_r  <= 1'b0;
                end
            endcase
        end
    end

    assign dut_in   = dut_in_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign pass     = pass_r;
    assign max_err  = max_err_r;
    assign mis_cnt  = mis_cnt_r;
    assign viol_cnt = viol_cnt_r;
    assign err_sum  = err_sum_r;

endmodule

// File: tb/tb_abs_diff_err_monitor.sv
// Scoreboard bench for abs_diff_err_monitor: two instances (ET=3 and ET=2)
// share control inputs and a response table standing in for the approximate
// circuit; expectations come from a plain arithmetic model of the sweep.
module tb_abs_diff_err_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] dut_in_a, dut_in_b;
    logic [1:0] dut_out_a, dut_out_b;
    logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;
    logic [1:0] max_err_a, max_err_b;
    logic [4:0] mis_a, viol_a, mis_b, viol_b;
    logic [5:0] sum_a, sum_b;

    logic [1:0] tbl [16];
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int kind;       // 0 = completes with done, 1 = aborted, 2 = reset
        int start_cyc;
        int mx, mis, viol, sum, pass;
        int viol_b, pass_b;
    } exp_t;
    exp_t q[$];

    assign dut_out_a = tbl[dut_in_a];
    assign dut_out_b = tbl[dut_in_b];

    abs_diff_err_monitor #(.IN_W(4), .OUT_W(2), .ET(3)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .dut_in(dut_in_a), .dut_out(dut_out_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .max_err(max_err_a), .mis_cnt(mis_a), .viol_cnt(viol_a),
        .err_sum(sum_a)
    );

    abs_diff_err_monitor #(.IN_W(4), .OUT_W(2), .ET(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .dut_in(dut_in_b), .dut_out(dut_out_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .max_err(max_err_b), .mis_cnt(mis_b), .viol_cnt(viol_b),
        .err_sum(sum_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response table: 0 exact, 1 tied to 0, 2 tied to 3, else random.
    task automatic set_table(input int mode);
        for (int v = 0; v < 16; v++) begin
            int a, b, d;
            a = v % 4;
            b = v / 4;
            d = (a > b) ? a - b : b - a;
            case (mode)
                0:       tbl[v] = 2'(d);
                1:       tbl[v] = 2'd0;
                2:       tbl[v] = 2'd3;
                default: tbl[v] = 2'($urandom_range(0, 3));
            endcase
        end
    endtask

    // Statistics over the first n vectors of the sweep for threshold et.
    function automatic void sweep_stats(input int et, input int n,
                                        output int mx, output int mis,
                                        output int viol, output int sum);
        mx = 0; mis = 0; viol = 0; sum = 0;
        for (int v = 0; v < n; v++) begin
            int a, b, ex, e;
            a  = v % 4;
            b  = v / 4;
            ex = (a > b) ? a - b : b - a;
            e  = ex - int'(tbl[v]);
            if (e < 0) e = -e;
            if (e != 0) mis++;
            if (e > et) viol++;
            sum += e;
            if (e > mx) mx = e;
        end
    endfunction

    function automatic exp_t make_exp(input int kind, input int n);
        exp_t e;
        int mx2, mis2, sum2;
        e.kind = kind;
        e.start_cyc = 0;
        sweep_stats(3, n, e.mx, e.mis, e.viol, e.sum);
        sweep_stats(2, n, mx2, mis2, e.viol_b, sum2);
        e.pass   = (kind == 0 && e.viol == 0) ? 1 : 0;
        e.pass_b = (kind == 0 && e.viol_b == 0) ? 1 : 0;
        return e;
    endfunction

    task automatic stats_check(input exp_t e);
        check("max_err",  int'(max_err_a), e.mx);
        check("mis_cnt",  int'(mis_a),     e.mis);
        check("viol_cnt", int'(viol_a),    e.viol);
        check("err_sum",  int'(sum_a),     e.sum);
        check("pass",     int'(pass_a),    e.pass);
        check("viol_cnt_et2", int'(viol_b), e.viol_b);
        check("pass_et2",     int'(pass_b), e.pass_b);
    endtask

    // Monitor: reacts to busy rising, done rising and busy falling without done.
    logic busy_p = 1'b0;
    logic done_p = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (busy_a && !busy_p) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_start: busy rose at cycle %0d with no sweep requested", cyc);
            end else begin
                check("start_cycle", cyc, q[0].start_cyc);
            end
        end
        if (done_a && !done_p) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: done rose at cycle %0d with nothing expected", cyc);
            end else begin
                e = q.pop_front();
                check("event_kind", 0, e.kind);
                check("done_latency", cyc - e.start_cyc, 18);
                check("busy_at_done", int'(busy_a), 0);
                stats_check(e);
            end
        end else if (busy_p && !busy_a) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_stop: busy fell at cycle %0d with nothing expected", cyc);
            end else begin
                e = q.pop_front();
                check("event_kind", rst_n ? 1 : 2, e.kind);
                check("done_after_stop", int'(done_a), 0);
                stats_check(e);
                if (e.kind == 2) check("dut_in_after_reset", int'(dut_in_a), 0);
            end
        end
        busy_p <= busy_a;
        done_p <= done_a;
    end

    task automatic do_start(output int sc);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sc = cyc;
    endtask

    task automatic wait_empty(input int bound);
        for (int i = 0; i < bound && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            checks++; errors++;
            $display("FAIL timeout: %0d expectation(s) pending after %0d cycles", q.size(), bound);
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic full_sweep(input int mode);
        exp_t e;
        int sc;
        set_table(mode);
        e = make_exp(0, 16);
        do_start(sc);
        e.start_cyc = sc;
        q.push_back(e);
        wait_empty(40);
    endtask

    // Abort sampled at the end of cycle j after the start edge.
    task automatic abort_sweep(input int mode, input int j, input logic with_start);
        exp_t e;
        int sc;
        set_table(mode);
        e = make_exp(1, (j == 0) ? 0 : j - 1);
        do_start(sc);
        e.start_cyc = sc;
        q.push_back(e);
        repeat (j) @(posedge clk);
        @(negedge clk);
        check("abort_vec", int'(dut_in_a), (j == 0) ? 0 : ((j > 16) ? 15 : j - 1));
        abort = 1'b1;
        start = with_start;
        @(posedge clk);
        #1;
        abort = 1'b0;
        start = 1'b0;
        wait_empty(5);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        exp_t e;
        int sc;
        set_table(0);
        repeat (2) @(negedge clk);
        check("rst_busy",  int'(busy_a), 0);
        check("rst_done",  int'(done_a), 0);
        check("rst_pass",  int'(pass_a), 0);
        check("rst_dut_in", int'(dut_in_a), 0);
        check("rst_stats", int'(max_err_a) + int'(mis_a) + int'(viol_a) + int'(sum_a), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        full_sweep(0);
        full_sweep(1);
        full_sweep(2);

        abort_sweep(1, 6, 1'b0);
        full_sweep(1);

        // start pulsed in RUN is ignored, abort in DONE is ignored, start in DONE restarts
        set_table(3);
        e = make_exp(0, 16);
        do_start(sc);
        e.start_cyc = sc;
        q.push_back(e);
        repeat (6) @(posedge clk);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_empty(40);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        repeat (2) @(negedge clk);
        abort = 1'b0;
        check("done_hold_abort", int'(done_a), 1);
        check("pass_hold_abort", int'(pass_a), e.pass);
        check("sum_hold_abort",  int'(sum_a), e.sum);
        full_sweep(3);

        // asynchronous reset mid-sweep
        set_table(1);
        e = make_exp(0, 16);
        do_start(sc);
        e.start_cyc = sc;
        q.push_back(e);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("reset_vec", int'(dut_in_a), 9);
        e = q.pop_front();
        e = make_exp(2, 0);
        q.push_front(e);
        #2 rst_n = 1'b0;
        #1;
        check("async_busy",   int'(busy_a), 0);
        check("async_dut_in", int'(dut_in_a), 0);
        check("async_mis",    int'(mis_a), 0);
        check("async_sum",    int'(sum_a), 0);
        wait_empty(3);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_after_reset", int'(busy_a), 0);
        full_sweep(0);

        // randomized sweeps and aborts
        for (int it = 0; it < 12; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                full_sweep(3);
            end else begin
                abort_sweep(3, int'($urandom_range(0, 17)), 1'($urandom_range(0, 1)));
            end
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
